data_mem_responder: RTL and testbench

- Responder end of the MEM-stage data port. Accepts data_request / write_enable / mem_byte_enable / mem_address / mem_wdata from the MEM-stage controller and answers with a one-cycle data_response plus mem_rdata.
- Backed by an internal word-organised SRAM array with a programmable fixed access latency.
- Serves as the data-side memory model for pipeline bring-up, and as the timing stand-in for the future data cache.

---
 rtl/data_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Responder end of the MEM-stage data port. A word-organised 16-bit SRAM model with
// a fixed, programmable access latency. It serves as the data memory for pipeline
// bring-up and as the timing stand-in for the future data cache.
//
// Parameters:
//   DEPTH_LOG2 - log2 of the number of 16-bit words. Word index is
//                mem_address[DEPTH_LOG2:1]; higher address bits alias.
//   LATENCY    - cycles from request acceptance to data_response (1..15).
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   synchronous active-low reset
//   data_request    in   valid access, held high until data_response
//   write_enable    in   1 = store, 0 = load
//   mem_address     in   byte address (bit 0 ignored for the word index)
//   mem_wdata       in   lane-aligned store data
//   mem_byte_enable in   bit1 = high lane, bit0 = low lane (stores only)
//   data_response   out  one-cycle completion pulse (RESP state)
//   mem_rdata       out  load data, valid in the response cycle and held afterwards
//   busy            out  access in flight (BUSY state)
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_request,
  input  logic        write_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        data_response,
  output logic [15:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  // An access accepted in cycle t responds in cycle t+LATENCY, so it spends
  // LATENCY-1 cycles in BUSY. The counter holds the number of BUSY cycles still
  // to come after the current one, hence the LATENCY-2 load value.
  localparam logic [3:0] CntInit    = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  // With LATENCY=1 there is no BUSY cycle at all: IDLE goes straight to RESP.
  localparam bit         DirectResp = (LATENCY <= 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [1:0]            be_q, be_d;
  logic [15:0]           rdata_q, rdata_d;

  logic [15:0]           mem_q [Depth];

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_we;
  logic                  enter_resp;
  logic                  unused_addr;

  assign req_idx = mem_address[DEPTH_LOG2:1];
  // Upper address bits and bit 0 are intentionally ignored (aliasing).
  assign unused_addr = ^mem_address;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    // Index/direction of the access about to enter RESP. When IDLE jumps straight
    // to RESP the latches are only being loaded now, so use the live inputs.
    rd_idx     = idx_q;
    rd_we      = we_q;

    unique case (state_q)
      StIdle: begin
        if (data_request) begin
          idx_d   = req_idx;
          we_d    = write_enable;
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          cnt_d   = CntInit;
          rd_idx  = req_idx;
          rd_we   = write_enable;
          if (DirectResp) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (!data_request) begin
          // Requester withdrew: abandon without response or write.
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Loads capture the array word on entry to RESP; stores leave mem_rdata alone.
    if (enter_resp && !rd_we) begin
      rdata_d = mem_q[rd_idx];
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Array: not reset. A store commits at the edge ending RESP unless reset is
  // asserted at that edge.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == StResp) && we_q) begin
      if (be_q[1]) begin
        mem_q[idx_q][15:8] <= wdata_q[15:8];
      end
      if (be_q[0]) begin
        mem_q[idx_q][7:0] <= wdata_q[7:0];
      end
    end
  end

  assign data_response = (state_q == StResp);
  assign busy          = (state_q == StBusy);
  assign mem_rdata     = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Two instances: the default configuration
// (LATENCY=2, DEPTH_LOG2=10) and a small one (LATENCY=1, DEPTH_LOG2=4) for
// aliasing and minimum latency. Expected values come from constants and a word
// array model updated by byte lane.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, we0, resp0, busy0;
  logic [15:0] addr0, wdata0, rdata0;
  logic [1:0]  be0;
  logic        req1, we1, resp1, busy1;
  logic [15:0] addr1, wdata1, rdata1;
  logic [1:0]  be1;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] ref0 [1024];

  data_mem_responder #(
    .DEPTH_LOG2(10),
    .LATENCY   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_request   (req0),
    .write_enable   (we0),
    .mem_address    (addr0),
    .mem_wdata      (wdata0),
    .mem_byte_enable(be0),
    .data_response  (resp0),
    .mem_rdata      (rdata0),
    .busy           (busy0)
  );

  data_mem_responder #(
    .DEPTH_LOG2(4),
    .LATENCY   (1)
  ) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_request   (req1),
    .write_enable   (we1),
    .mem_address    (addr1),
    .mem_wdata      (wdata1),
    .mem_byte_enable(be1),
    .data_response  (resp1),
    .mem_rdata      (rdata1),
    .busy           (busy1)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int u, input logic req, input logic we, input logic [15:0] a,
                       input logic [15:0] w, input logic [1:0] be);
    if (u == 0) begin
      req0 = req; we0 = we; addr0 = a; wdata0 = w; be0 = be;
    end else begin
      req1 = req; we1 = we; addr1 = a; wdata1 = w; be1 = be;
    end
  endtask

  // Presents an access in the current cycle and waits for its response. lat is the
  // number of edges until the response cycle (-1 on timeout). With keep=0 the
  // request is dropped and one more cycle passes, so the DUT is IDLE on return.
  task automatic access(input int u, input logic we, input logic [15:0] a,
                        input logic [15:0] w, input logic [1:0] be, input bit keep,
                        output int lat, output int busy_cnt, output logic [15:0] rd);
    logic r, b;
    drive(u, 1'b1, we, a, w, be);
    lat      = -1;
    busy_cnt = 0;
    rd       = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      r = (u == 0) ? resp0 : resp1;
      b = (u == 0) ? busy0 : busy1;
      if (r === 1'b1) begin
        lat = n;
        rd  = (u == 0) ? rdata0 : rdata1;
        break;
      end
      if (b === 1'b1) busy_cnt++;
    end
    if (!keep) begin
      drive(u, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      vectors++;
      if (resp0 !== 1'b0) begin
        miscompares++; $display("FAIL reset_resp: got %b expected 0", resp0);
      end
      vectors++;
      if (rdata0 !== 16'h0000) begin
        miscompares++; $display("FAIL reset_rdata: got %h expected 0000", rdata0);
      end
      vectors++;
      if (busy0 !== 1'b0) begin
        miscompares++; $display("FAIL reset_busy: got %b expected 0", busy0);
      end
    end
  endtask

  task automatic test_store_load();
    int lat, bc;
    logic [15:0] rd;
    access(0, 1'b1, 16'h0040, 16'hBEEF, 2'b11, 1'b1, lat, bc, rd);
    ref0[10'h020] = 16'hBEEF;
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL store_lat: got %0d expected 2", lat); end
    vectors++;
    if (bc !== 1) begin miscompares++; $display("FAIL store_busy: got %0d expected 1", bc); end
    vectors++;
    if (rd !== 16'h0000) begin
      miscompares++; $display("FAIL store_hold: got %h expected 0000", rd);
    end
    // Back-to-back: request stays high, next response LATENCY+1 after the first.
    access(0, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL b2b_lat: got %0d expected 3", lat); end
    vectors++;
    if (rd !== 16'hBEEF) begin miscompares++; $display("FAIL b2b_load: got %h expected beef", rd); end
    vectors++;
    if (resp0 !== 1'b0) begin miscompares++; $display("FAIL pulse_width: got %b expected 0", resp0); end
  endtask

  task automatic test_partial();
    int lat, bc;
    logic [15:0] rd;
    access(0, 1'b1, 16'h0041, 16'h1200, 2'b10, 1'b0, lat, bc, rd);
    ref0[10'h020][15:8] = 8'h12;
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL hi_store_lat: got %0d expected 2", lat); end
    vectors++;
    if (rd !== 16'hBEEF) begin miscompares++; $display("FAIL hi_store_hold: got %h expected beef", rd); end
    access(0, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (rd !== 16'h12EF) begin miscompares++; $display("FAIL hi_lane: got %h expected 12ef", rd); end
    access(0, 1'b1, 16'h0040, 16'hFFFF, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL be00_resp: got %0d expected 2", lat); end
    access(0, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (rd !== 16'h12EF) begin miscompares++; $display("FAIL be00_nowrite: got %h expected 12ef", rd); end
  endtask

  task automatic test_ldi();
    int lat, bc;
    logic [15:0] rd;
    access(0, 1'b1, 16'h0010, 16'h0200, 2'b11, 1'b0, lat, bc, rd);
    access(0, 1'b1, 16'h0200, 16'hA5C3, 2'b11, 1'b0, lat, bc, rd);
    ref0[10'h008] = 16'h0200;
    ref0[10'h100] = 16'hA5C3;
    access(0, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, lat, bc, rd);
    vectors++;
    if (lat !== 2 || rd !== 16'h0200) begin
      miscompares++; $display("FAIL ldi_ptr: got lat %0d data %h expected lat 2 data 0200", lat, rd);
    end
    access(0, 1'b0, rd, 16'h0000, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (lat !== 3 || rd !== 16'hA5C3) begin
      miscompares++; $display("FAIL ldi_data: got lat %0d data %h expected lat 3 data a5c3", lat, rd);
    end
  endtask

  task automatic test_abort();
    int lat, bc;
    logic [15:0] rd;
    drive(0, 1'b1, 1'b1, 16'h0040, 16'h0000, 2'b11);
    tick(1);
    vectors++;
    if (busy0 !== 1'b1) begin miscompares++; $display("FAIL abort_busy: got %b expected 1", busy0); end
    drive(0, 1'b0, 1'b1, 16'h0040, 16'h0000, 2'b11);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      vectors++;
      if (resp0 !== 1'b0) begin miscompares++; $display("FAIL abort_resp: got %b expected 0", resp0); end
    end
    access(0, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (rd !== 16'h12EF) begin miscompares++; $display("FAIL abort_nowrite: got %h expected 12ef", rd); end
  endtask

  task automatic test_reset_in_resp();
    int lat, bc;
    logic [15:0] rd;
    access(0, 1'b1, 16'h0040, 16'h7777, 2'b11, 1'b1, lat, bc, rd);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL rst_store_lat: got %0d expected 2", lat); end
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    tick(1);
    vectors++;
    if (resp0 !== 1'b0 || rdata0 !== 16'h0000 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_outputs: got resp %b rdata %h busy %b expected 0 0000 0",
               resp0, rdata0, busy0);
    end
    rst_n = 1'b1;
    tick(1);
    access(0, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (rd !== 16'h12EF) begin miscompares++; $display("FAIL rst_nowrite: got %h expected 12ef", rd); end
  endtask

  task automatic test_alias_lat1();
    int lat, bc;
    logic [15:0] rd;
    access(1, 1'b1, 16'h0002, 16'h5555, 2'b11, 1'b0, lat, bc, rd);
    vectors++;
    if (lat !== 1 || bc !== 0) begin
      miscompares++; $display("FAIL l1_store: got lat %0d busy %0d expected lat 1 busy 0", lat, bc);
    end
    access(1, 1'b0, 16'h0022, 16'h0000, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (lat !== 1 || rd !== 16'h5555) begin
      miscompares++; $display("FAIL l1_alias: got lat %0d data %h expected lat 1 data 5555", lat, rd);
    end
    access(1, 1'b1, 16'h0004, 16'hAAAA, 2'b11, 1'b1, lat, bc, rd);
    access(1, 1'b0, 16'h0024, 16'h0000, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (lat !== 2 || rd !== 16'hAAAA) begin
      miscompares++; $display("FAIL l1_b2b: got lat %0d data %h expected lat 2 data aaaa", lat, rd);
    end
  endtask

  task automatic test_random();
    int lat, bc, exp_lat;
    logic [15:0] rd, exp_rd, a, w;
    logic [9:0]  idx;
    logic [4:0]  hi;
    logic        lo, we;
    logic [1:0]  be;
    bit          keep, prev_keep;
    for (int i = 0; i < 16; i++) begin
      idx = 10'h180 + 10'(i);
      hi  = 5'($urandom);
      lo  = 1'($urandom);
      w   = 16'($urandom);
      access(0, 1'b1, {hi, idx, lo}, w, 2'b11, 1'b0, lat, bc, rd);
      ref0[idx] = w;
    end
    idx = 10'h180;
    access(0, 1'b0, {5'h03, idx, 1'b0}, 16'h0000, 2'b00, 1'b0, lat, bc, rd);
    vectors++;
    if (rd !== ref0[idx]) begin
      miscompares++; $display("FAIL rnd_first: got %h expected %h", rd, ref0[idx]);
    end
    exp_rd    = ref0[idx];
    prev_keep = 1'b0;
    for (int i = 0; i < 60; i++) begin
      idx  = 10'h180 + 10'($urandom_range(0, 15));
      hi   = 5'($urandom);
      lo   = 1'($urandom);
      a    = {hi, idx, lo};
      w    = 16'($urandom);
      we   = 1'($urandom);
      be   = 2'($urandom);
      keep = (i == 59) ? 1'b0 : 1'($urandom);
      access(0, we, a, w, be, keep, lat, bc, rd);
      exp_lat = prev_keep ? 3 : 2;
      vectors++;
      if (lat !== exp_lat) begin
        miscompares++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", i, lat, exp_lat);
      end
      if (we) begin
        vectors++;
        if (rd !== exp_rd) begin
          miscompares++; $display("FAIL rnd_store_hold[%0d]: got %h expected %h", i, rd, exp_rd);
        end
        if (be[1]) ref0[idx][15:8] = w[15:8];
        if (be[0]) ref0[idx][7:0]  = w[7:0];
      end else begin
        vectors++;
        if (rd !== ref0[idx]) begin
          miscompares++; $display("FAIL rnd_load[%0d]: got %h expected %h", i, rd, ref0[idx]);
        end
        exp_rd = ref0[idx];
      end
      prev_keep = keep;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial();
    test_ldi();
    test_abort();
    test_reset_in_resp();
    test_alias_lat1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
